// File: rtl/real_bits_deser.sv
// rtl/real_bits_deser.sv - reassembles 64-bit IEEE-754 double patterns from BEAT_W-bit stream beats
// Little-endian beat order, registered classification flags, framing error pulse.
module real_bits_deser #(
  parameter int BEAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BEAT_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_bits,
  output logic              out_sign,
  output logic              out_is_zero,
  output logic              out_is_inf,
  output logic              out_is_nan,
  output logic              err_frame
);

  localparam int BEATS = 64 / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  generate
    if (BEAT_W != 8 && BEAT_W != 16 && BEAT_W != 32 && BEAT_W != 64) begin : g_bad_beat_w
      $error("real_bits_deser: BEAT_W must be 8, 16, 32 or 64");
    end
  endgenerate

  logic [CNT_W-1:0] r_cnt;
  logic [63:0]      r_buf;
  logic             r_out_valid;
  logic [63:0]      r_out_bits;
  logic             r_is_zero;
  logic             r_is_inf;
  logic             r_is_nan;
  logic             r_err;

  logic        w_last_slot;
  logic        w_acc;
  logic        w_done;
  logic        w_err;
  logic [63:0] w_frame;
  logic [10:0] w_exp;
  logic [51:0] w_man;

  assign w_last_slot = (r_cnt == LAST_CNT);
  // Only the final slot has to wait for the output register to drain.
  assign in_ready    = !w_last_slot || !r_out_valid || out_ready;
  assign w_acc       = in_valid && in_ready;
  assign w_done      = w_acc && w_last_slot && in_last;
  assign w_err       = w_acc && (w_last_slot ? !in_last : in_last);

  always_comb begin
    w_frame = r_buf;
    w_frame[(BEATS-1)*BEAT_W +: BEAT_W] = in_data;
  end

  assign w_exp = w_frame[62:52];
  assign w_man = w_frame[51:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_buf       <= '0;
      r_out_valid <= 1'b0;
      r_out_bits  <= '0;
      r_is_zero   <= 1'b0;
      r_is_inf    <= 1'b0;
      r_is_nan    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_err;
      if (w_acc) begin
        r_cnt <= (w_last_slot || in_last) ? '0 : r_cnt + CNT_W'(1);
        for (int k = 0; k < BEATS; k++) begin
          if (r_cnt == CNT_W'(k)) r_buf[k*BEAT_W +: BEAT_W] <= in_data;
        end
      end
      if (w_done) begin
        r_out_valid <= 1'b1;
        r_out_bits  <= w_frame;
        r_is_zero   <= (w_exp == 11'h000) && (w_man == '0);
        r_is_inf    <= (w_exp == 11'h7FF) && (w_man == '0);
        r_is_nan    <= (w_exp == 11'h7FF) && (w_man != '0);
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_bits    = r_out_bits;
  assign out_sign    = r_out_bits[63];
  assign out_is_zero = r_is_zero;
  assign out_is_inf  = r_is_inf;
  assign out_is_nan  = r_is_nan;
  assign err_frame   = r_err;

endmodule
